// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer sequencer.
// The state encoding is 3 bits so that unused codes can be detected and recovered.
package countdown_pkg;

   typedef enum logic [2:0] {
      EDIT  = 3'd0,
      ARMED = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd_pair_t;

   localparam bcd_pair_t BCD_PAIR_ZERO = 8'h00;

endpackage

// File: rtl/countdown_prescaler.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled and reports the last count as a tick.
// Holding enable low freezes the count, so a paused timer keeps its partial second.
module countdown_prescaler #(
   parameter int unsigned TICKS_PER_SEC = 32'd1000000,
   localparam int unsigned CW = (TICKS_PER_SEC > 32'd1) ? $clog2(TICKS_PER_SEC) : 32'd1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 32'd1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = enable && (cnt_q == LAST);

   // Next count: clear dominates, otherwise advance and wrap while enabled.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown timer sequencer: preset entry, arm, run, pause and alarm over a 2-digit BCD count.
// All outputs are registered and derived from the next-state values.
module countdown_ctrl
   import countdown_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 32'd1000000,
   parameter int unsigned ALARM_SEC     = 32'd3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       keydown_num,
   input  logic [3:0] num,
   input  logic       keydown_confirm,
   input  logic       keydown_clear,
   input  logic       keydown_start,
   output logic [3:0] disp_tens,
   output logic [3:0] disp_ones,
   output logic       editing,
   output logic       running,
   output logic       paused,
   output logic       alarm
);

   localparam int unsigned AW = (ALARM_SEC > 32'd1) ? $clog2(ALARM_SEC) : 32'd1;
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 32'd1);

   state_e    state_q,  state_d;
   bcd_pair_t entry_q,  entry_d;
   bcd_pair_t preset_q, preset_d;
   bcd_pair_t count_q,  count_d;
   bcd_pair_t disp_q,   disp_d;
   logic [AW-1:0] sec_q, sec_d;
   logic editing_q, editing_d;
   logic running_q, running_d;
   logic paused_q,  paused_d;
   logic alarm_q,   alarm_d;

   logic ev_clear_s, ev_start_s, ev_confirm_s, ev_num_s, any_key_s;
   logic presc_en_s, presc_clr_s, tick_s;
   bcd_pair_t dec_s;

   // Resolve simultaneous pulses to a single event: clear > start > confirm > num.
   always_comb begin
      ev_clear_s   = keydown_clear;
      ev_start_s   = keydown_start & ~keydown_clear;
      ev_confirm_s = keydown_confirm & ~keydown_start & ~keydown_clear;
      ev_num_s     = keydown_num & ~keydown_confirm & ~keydown_start & ~keydown_clear
                     & (num <= BCD_NINE);
      any_key_s    = keydown_num | keydown_confirm | keydown_clear | keydown_start;
   end

   // A key action in the tick cycle freezes the prescaler so the tick is discarded, not deferred.
   always_comb begin
      presc_en_s  = ((state_q == RUN) & ~(ev_clear_s | ev_start_s))
                  | ((state_q == DONE) & ~any_key_s);
      presc_clr_s = ~((state_q == RUN) | (state_q == PAUSE) | (state_q == DONE));
   end

   countdown_prescaler #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clear  (presc_clr_s),
      .enable (presc_en_s),
      .tick   (tick_s)
   );

   // BCD decrement with borrow from tens.
   always_comb begin
      dec_s = count_q;
      if (count_q.ones == BCD_ZERO) begin
         dec_s.ones = BCD_NINE;
         dec_s.tens = count_q.tens - 4'd1;
      end else begin
         dec_s.ones = count_q.ones - 4'd1;
      end
   end

   // Next-state logic for the sequencer and its datapath registers.
   always_comb begin
      state_d  = state_q;
      entry_d  = entry_q;
      preset_d = preset_q;
      count_d  = count_q;
      sec_d    = '0;
      case (state_q)
         EDIT: begin
            if (ev_clear_s) begin
               entry_d = BCD_PAIR_ZERO;
            end else if (ev_confirm_s) begin
               if (entry_q != BCD_PAIR_ZERO) begin
                  preset_d = entry_q;
                  count_d  = entry_q;
                  state_d  = ARMED;
               end else begin
                  state_d = EDIT;
               end
            end else if (ev_num_s) begin
               entry_d = '{tens: entry_q.ones, ones: num};
            end else begin
               entry_d = entry_q;
            end
         end
         ARMED: begin
            if (ev_clear_s) begin
               entry_d = BCD_PAIR_ZERO;
               state_d = EDIT;
            end else if (ev_start_s) begin
               state_d = RUN;
            end else begin
               state_d = ARMED;
            end
         end
         RUN: begin
            if (ev_clear_s) begin
               entry_d = BCD_PAIR_ZERO;
               state_d = EDIT;
            end else if (ev_start_s) begin
               state_d = PAUSE;
            end else if (tick_s) begin
               count_d = dec_s;
               if (dec_s == BCD_PAIR_ZERO) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         PAUSE: begin
            if (ev_clear_s) begin
               count_d = preset_q;
               state_d = ARMED;
            end else if (ev_start_s) begin
               state_d = RUN;
            end else begin
               state_d = PAUSE;
            end
         end
         DONE: begin
            sec_d = sec_q;
            if (any_key_s) begin
               count_d = preset_q;
               sec_d   = '0;
               state_d = ARMED;
            end else if (tick_s) begin
               if (sec_q == ALARM_LAST) begin
                  count_d = preset_q;
                  sec_d   = '0;
                  state_d = ARMED;
               end else begin
                  sec_d = sec_q + AW'(1);
               end
            end else begin
               sec_d = sec_q;
            end
         end
         default: begin
            state_d  = EDIT;
            entry_d  = BCD_PAIR_ZERO;
            preset_d = BCD_PAIR_ZERO;
            count_d  = BCD_PAIR_ZERO;
            sec_d    = '0;
         end
      endcase
   end

   // Output values follow the state being entered so they change on the same edge.
   always_comb begin
      editing_d = (state_d == EDIT);
      running_d = (state_d == RUN);
      paused_d  = (state_d == PAUSE);
      alarm_d   = (state_d == DONE);
      if (state_d == EDIT) begin
         disp_d = entry_d;
      end else if (state_d == DONE) begin
         disp_d = BCD_PAIR_ZERO;
      end else begin
         disp_d = count_d;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= EDIT;
         entry_q   <= BCD_PAIR_ZERO;
         preset_q  <= BCD_PAIR_ZERO;
         count_q   <= BCD_PAIR_ZERO;
         sec_q     <= '0;
         disp_q    <= BCD_PAIR_ZERO;
         editing_q <= 1'b1;
         running_q <= 1'b0;
         paused_q  <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         entry_q   <= entry_d;
         preset_q  <= preset_d;
         count_q   <= count_d;
         sec_q     <= sec_d;
         disp_q    <= disp_d;
         editing_q <= editing_d;
         running_q <= running_d;
         paused_q  <= paused_d;
         alarm_q   <= alarm_d;
      end
   end

   assign disp_tens = disp_q.tens;
   assign disp_ones = disp_q.ones;
   assign editing   = editing_q;
   assign running   = running_q;
   assign paused    = paused_q;
   assign alarm     = alarm_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl with TICKS_PER_SEC=4 and ALARM_SEC=2.
// Flags are checked as {editing, running, paused, alarm}.
module tb_countdown_ctrl;

   logic       clk;
   logic       rst;
   logic       keydown_num;
   logic [3:0] num;
   logic       keydown_confirm;
   logic       keydown_clear;
   logic       keydown_start;
   logic [3:0] disp_tens;
   logic [3:0] disp_ones;
   logic       editing;
   logic       running;
   logic       paused;
   logic       alarm;

   int checks;
   int errors;

   countdown_ctrl #(
      .TICKS_PER_SEC (32'd4),
      .ALARM_SEC     (32'd2)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .keydown_num     (keydown_num),
      .num             (num),
      .keydown_confirm (keydown_confirm),
      .keydown_clear   (keydown_clear),
      .keydown_start   (keydown_start),
      .disp_tens       (disp_tens),
      .disp_ones       (disp_ones),
      .editing         (editing),
      .running         (running),
      .paused          (paused),
      .alarm           (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply inputs for exactly one rising edge, then sample 1 ns after it.
   task automatic drive(input logic r, input logic c, input logic s, input logic f,
                        input logic nk, input logic [3:0] n);
      rst = r; keydown_clear = c; keydown_start = s; keydown_confirm = f;
      keydown_num = nk; num = n;
      @(posedge clk);
      #1;
      rst = 1'b0; keydown_clear = 1'b0; keydown_start = 1'b0; keydown_confirm = 1'b0;
      keydown_num = 1'b0; num = 4'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   task automatic dig(input logic [3:0] n);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n);
   endtask

   task automatic k_clear();   drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0); endtask
   task automatic k_start();   drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0); endtask
   task automatic k_confirm(); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0); endtask

   task automatic check(input string tag, input logic [7:0] exp_disp, input logic [3:0] exp_flags);
      logic [7:0] obs_disp;
      logic [3:0] obs_flags;
      obs_disp  = {disp_tens, disp_ones};
      obs_flags = {editing, running, paused, alarm};
      checks++;
      assert (obs_disp === exp_disp) else begin
         errors++;
         $error("FAIL %s disp: observed %h expected %h", tag, obs_disp, exp_disp);
      end
      checks++;
      assert (obs_flags === exp_flags) else begin
         errors++;
         $error("FAIL %s flags: observed %b expected %b", tag, obs_flags, exp_flags);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1; keydown_num = 1'b0; num = 4'd0;
      keydown_confirm = 1'b0; keydown_clear = 1'b0; keydown_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset", 8'h00, 4'b1000);

      // Digit entry shifts left; out-of-range digits are ignored.
      dig(4'd6);          check("dig6", 8'h06, 4'b1000);
      dig(4'd8);          check("dig8", 8'h68, 4'b1000);
      dig(4'd3);          check("dig3_drop_tens", 8'h83, 4'b1000);
      dig(4'hC);          check("dig_gt9_ignored", 8'h83, 4'b1000);
      k_clear();          check("edit_clear", 8'h00, 4'b1000);
      k_confirm();        check("confirm_zero_ignored", 8'h00, 4'b1000);

      // Full run of preset 03 into DONE and auto-rearm.
      dig(4'd0);
      dig(4'd3);          check("entry03", 8'h03, 4'b1000);
      k_confirm();        check("armed03", 8'h03, 4'b0000);
      k_start();          check("run_start", 8'h03, 4'b0100);
      idle(3);            check("run_plus3", 8'h03, 4'b0100);
      idle(1);            check("run_plus4", 8'h02, 4'b0100);
      idle(4);            check("run_plus8", 8'h01, 4'b0100);
      idle(4);            check("done_plus12", 8'h00, 4'b0001);
      idle(7);            check("done_hold", 8'h00, 4'b0001);
      idle(1);            check("auto_rearm", 8'h03, 4'b0000);

      // Pause preserves the partial second.
      k_clear();          check("armed_clear", 8'h00, 4'b1000);
      dig(4'd0);
      dig(4'd5);
      k_confirm();        check("armed05", 8'h05, 4'b0000);
      k_start();
      idle(4);            check("run05_first_tick", 8'h04, 4'b0100);
      idle(2);
      k_start();          check("pause", 8'h04, 4'b0010);
      idle(20);           check("pause_hold", 8'h04, 4'b0010);
      k_start();          check("resume", 8'h04, 4'b0100);
      idle(1);            check("resume_plus1", 8'h04, 4'b0100);
      idle(1);            check("resume_plus2", 8'h03, 4'b0100);

      // Start coinciding with a tick: tick dropped, it fires one cycle after resume.
      idle(3);
      k_start();          check("pause_on_tick", 8'h03, 4'b0010);
      k_start();          check("resume_at_last", 8'h03, 4'b0100);
      idle(1);            check("tick_after_resume", 8'h02, 4'b0100);

      // Clear beats start in the same cycle.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      check("clear_start_run", 8'h00, 4'b1000);

      // BCD borrow 10 -> 09, then pause and clear back to the preset.
      dig(4'd1);
      dig(4'd0);          check("entry10", 8'h10, 4'b1000);
      k_confirm();
      k_start();          check("run10", 8'h10, 4'b0100);
      idle(4);            check("borrow_09", 8'h09, 4'b0100);
      k_start();          check("pause09", 8'h09, 4'b0010);
      k_clear();          check("pause_clear", 8'h10, 4'b0000);

      // Preset 01: DONE exit by key, then reset with a key pulse in DONE.
      k_clear();
      dig(4'd1);
      k_confirm();
      k_start();
      idle(4);            check("done01", 8'h00, 4'b0001);
      k_start();          check("done_key_exit", 8'h01, 4'b0000);
      k_start();
      idle(4);            check("done01_again", 8'h00, 4'b0001);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      check("rst_in_done", 8'h00, 4'b1000);
      k_confirm();        check("preset_lost", 8'h00, 4'b1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
